// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the slow-clock edge monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int CNT_W_DEF   = 24;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises the asynchronous slow clock into clk and emits registered
// one-cycle rise/fall strobes, SYNC_STAGES+1 cycles after the input moves.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  // Shift slow_in through the chain, keep one delayed copy, register strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], slow_in};
      sync_d <= sync_out;
      rise   <= sync_out & ~sync_d;
      fall   <= ~sync_out & sync_d;
    end
  end

endmodule

// File: rtl/clk_edge_monitor.sv
// Measures the edge-to-edge interval of a slow divided clock in clk cycles,
// declares lock once consecutive intervals agree within TOL, and flags loss
// when no edge arrives for TIMEOUT cycles.
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  LOCK_V  = MC_W'(LOCK_COUNT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, prev_hp, prev_n, hp_n, m, diff;
  logic [MC_W-1:0]  match_cnt, match_n, match_inc;
  logic             have_prev, have_n, mv_n;
  logic             edge_s, is_match, timeout;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .slow_in (slow_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign edge_s    = rise | fall;
  assign m         = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  assign diff      = (m >= prev_hp) ? m - prev_hp : prev_hp - m;
  assign is_match  = diff <= TOL_V;
  assign timeout   = (cnt == TO_LAST) && !edge_s;
  assign match_inc = (match_cnt >= LOCK_V) ? LOCK_V : match_cnt + MC_W'(1);

  // Next-state and measurement bookkeeping; edge takes priority over timeout.
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    prev_n  = prev_hp;
    hp_n    = half_period;
    have_n  = have_prev;
    mv_n    = 1'b0;
    unique case (state)
      IDLE, LOST: begin
        // Interval ending here is meaningless, so this edge only arms.
        if (edge_s) begin
          state_n = ACQUIRE;
          match_n = '0;
          have_n  = 1'b0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (edge_s) begin
          hp_n   = m;
          mv_n   = 1'b1;
          prev_n = m;
          if (!have_prev) begin
            have_n  = 1'b1;
            match_n = '0;
          end else if (is_match) begin
            match_n = match_inc;
            if (match_inc == LOCK_V) state_n = LOCKED;
          end else begin
            match_n = '0;
            state_n = ACQUIRE;
          end
        end else if (timeout) begin
          state_n = LOST;
          match_n = '0;
          have_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, measurement and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      match_cnt   <= '0;
      prev_hp     <= '0;
      have_prev   <= 1'b0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_n;
      match_cnt   <= match_n;
      prev_hp     <= prev_n;
      have_prev   <= have_n;
      half_period <= hp_n;
      meas_valid  <= mv_n;
      locked      <= (state_n == LOCKED);
      lost        <= (state_n == LOST);
    end
  end

  // Interval counter: restarts on each edge, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (edge_s)         cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor with a half_period scoreboard.
module tb_clk_edge_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slow_in = 1'b0;
  logic        slow2 = 1'b0;
  logic        rise, fall, meas_valid, locked, lost;
  logic [23:0] half_period;
  logic        rise2, fall2, mv2, locked2, lost2;
  logic [7:0]  hp2;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int both_cnt = 0;
  int mon_e;
  int r0;
  int exp_q[$];

  always #5 clk = ~clk;

  clk_edge_monitor #(.CNT_W(24), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(1), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .slow_in(slow_in), .rise(rise), .fall(fall),
    .half_period(half_period), .meas_valid(meas_valid), .locked(locked), .lost(lost)
  );

  clk_edge_monitor #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(1), .TIMEOUT(255)) dut8 (
    .clk(clk), .rst_n(rst_n), .slow_in(slow2), .rise(rise2), .fall(fall2),
    .half_period(hp2), .meas_valid(mv2), .locked(locked2), .lost(lost2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Toggle slow_in after wait_n posedges; queue the interval if it is measured.
  task automatic tog(input int wait_n, input int exp_m);
    repeat (wait_n) @(posedge clk);
    #1 slow_in = ~slow_in;
    if (exp_m > 0) exp_q.push_back(exp_m);
  endtask

  // Let the last edge reach the outputs: 5 posedges then sample on negedge.
  task automatic settle();
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  // Strobe counters and scoreboard compare on each measurement.
  always @(negedge clk) begin
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
    if (rise && fall) both_cnt++;
    if (meas_valid) begin
      mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("half_period", half_period, mon_e);
    end
  end

  initial begin
    // Reset held while slow_in toggles
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(posedge clk);
      #1 slow_in = ~slow_in;
    end
    @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lost, 0);
    chk("rst_hp", half_period, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_strobes", rise_cnt + fall_cnt, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_strobes", rise_cnt + fall_cnt, 0);

    // Steady 17-cycle toggling: lock on the 6th edge
    tog(5, 0);
    for (int i = 0; i < 4; i++) tog(17, 17);
    settle();
    chk("lock_pre", locked, 0);
    tog(12, 17);
    @(posedge clk); @(negedge clk);
    chk("lat_p1", rise | fall, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_p2", rise | fall, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_p3_fall", fall, 1);
    chk("lat_p3_rise", rise, 0);
    chk("lock_not_yet", locked, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_p4", fall, 0);
    chk("lock_6th", locked, 1);
    chk("hp_17", half_period, 17);
    chk("lost_0", lost, 0);
    chk("rise_cnt", rise_cnt, 3);
    chk("fall_cnt", fall_cnt, 3);

    // Jitter within tolerance keeps lock; a 20 breaks it
    tog(13, 17);
    tog(18, 18);
    tog(17, 17);
    tog(16, 16);
    settle();
    chk("jitter_locked", locked, 1);
    tog(15, 20);
    settle();
    chk("jump_unlock", locked, 0);
    tog(12, 17);
    for (int i = 0; i < 3; i++) tog(17, 17);
    settle();
    chk("relock_pre", locked, 0);
    tog(12, 17);
    settle();
    chk("relock", locked, 1);

    // Stall: lost after TIMEOUT cycles without an edge
    repeat (1010) @(posedge clk);
    @(negedge clk);
    chk("stall_early_lost", lost, 0);
    chk("stall_early_locked", locked, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_lost", lost, 1);
    chk("stall_locked", locked, 0);
    chk("stall_hp_hold", half_period, 17);
    tog(3, 0);
    settle();
    chk("resume_lost", lost, 0);
    chk("resume_locked", locked, 0);
    tog(12, 17);
    for (int i = 0; i < 4; i++) tog(17, 17);
    settle();
    chk("resume_relock", locked, 1);

    // Asynchronous reset mid-interval while locked
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_hp", half_period, 0);
    chk("arst_lost", lost, 0);
    slow_in = 1'b1;
    r0 = rise_cnt;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("release_rise", rise_cnt - r0, 1);
    tog(12, 17);
    for (int i = 0; i < 4; i++) tog(17, 17);
    settle();
    chk("arst_relock", locked, 1);

    // Narrow instance: edge lands on cnt == TIMEOUT-1, measured as 255
    @(posedge clk);
    #1 slow2 = 1'b1;
    repeat (255) @(posedge clk);
    #1 slow2 = 1'b0;
    settle();
    chk("sat_hp", hp2, 255);
    chk("sat_no_lost", lost2, 0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("sat_timeout_lost", lost2, 1);
    chk("sat_hp_hold", hp2, 255);

    chk("queue_empty", exp_q.size(), 0);
    chk("both_strobes", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
